param_reg_file: RTL and testbench
=================================

// Module: param_reg_file
// PURPOSE
//   Parametrised multi-port register file with write-to-read bypass, optional hardwired-zero register,
//   per-register busy scoreboard and write-conflict flag. Generalises the 32x32 two-read/one-write file:
//   sits between the ALU result mux and the ALU operand inputs, feeding N_RD operands per cycle.
//   Allows N_WR results (ALU, load path) to retire per cycle.
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W    5   address width; depth = 2**ADDR_W registers
//   N_RD      2   number of read ports (1..4)
//   N_WR      2   number of write ports (1..2)
//   ZERO_REG  0   1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary
//   BYPASS    1   1: same-cycle write data is forwarded to matching read ports; 0: reads return stored value
// PORTS
//   Clk        in   1              rising-edge clock
//   Rst        in   1              asynchronous, active-high reset
//   RdAddr     in   N_RD*ADDR_W    read addresses; port p = bits [p*ADDR_W +: ADDR_W]
//   RdData     out  N_RD*DATA_W    read data, combinational, port p = [p*DATA_W +: DATA_W]
//   RdBusy     out  N_RD           scoreboard busy bit of the register addressed by each read port
//   WrEn       in   N_WR           write enables
//   WrAddr     in   N_WR*ADDR_W    write addresses
//   WrData     in   N_WR*DATA_W    write data (signed two's complement, stored verbatim)
//   IssueEn    in   1              mark register IssueAddr busy (result pending)
//   IssueAddr  in   ADDR_W         register being reserved
//   WrConflict out  1              registered: pulses 1 cycle after >=2 enabled write ports hit the same address
// BEHAVIOUR
//   Reset (async, Rst=1): all registers <= 0, all busy bits <= 0, WrConflict <= 0; RdData therefore reads 0.
//     Rst asserted mid-cycle overrides any write/issue in progress; first write accepted on first posedge after Rst falls.
//   Write: on posedge Clk, for each port w with WrEn[w]=1, reg[WrAddr[w]] <= WrData[w]; latency 1 cycle to storage.
//     Same address on several ports: highest-index port wins; WrConflict <= 1 next cycle, else WrConflict <= 0.
//     ZERO_REG=1: writes to address 0 discarded, do not raise WrConflict, do not change busy.
//   Read: RdData[p] = reg[RdAddr[p]], purely combinational, any number of ports may read the same address.
//     BYPASS=1: if some enabled write port targets RdAddr[p] this cycle, RdData[p] = that WrData
//     (highest-index matching port), i.e. 0-cycle read-after-write. BYPASS=0: old value until after the edge.
//     ZERO_REG=1: RdData[p] = 0 whenever RdAddr[p]=0, overriding bypass.
//   Scoreboard: busy[IssueAddr] <= 1 on posedge when IssueEn; busy[a] <= 0 on posedge when any write port writes a.
//     Issue and write to same address in same cycle: issue wins (busy stays/becomes 1, new result still pending).
//     IssueEn to address 0 with ZERO_REG=1 ignored. RdBusy[p] = busy[RdAddr[p]] (registered state, no bypass).
//   No X propagation: out-of-range addresses impossible (depth = 2**ADDR_W); all state defined after reset.
// TESTING
//   Reset: Rst=1 with random prior contents -> all RdData=0, RdBusy=0, WrConflict=0 immediately (async).
//   Write/read: WrEn=01, WrAddr0=1, WrData0=1200; next cycle RdAddr0=1 -> RdData0=1200; reg31 <= -2 -> reads 32'hFFFFFFFE.
//   Bypass: WrEn0 to reg 3 with -2000 while RdAddr1=3 same cycle -> RdData1=-2000 (BYPASS=1), old value (BYPASS=0).
//   Conflict: both ports write reg 5 (10, 20) -> reg5=20, WrConflict=1 for exactly one cycle, then 0.
//   Scoreboard: IssueEn reg 7 -> RdBusy=1 next cycle; write reg 7 -> RdBusy=0; issue+write reg 7 same cycle -> stays 1.
//   Zero reg (ZERO_REG=1): write 55 to reg 0 -> RdData=0, no busy, no conflict; Rst pulsed mid-write -> write lost, all 0.

Source files
------------

// File: rtl/param_reg_file.sv
// Multi-port register file with write-to-read bypass, optional hardwired zero register,
// per-register busy scoreboard and registered same-address write-conflict flag.
module param_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int N_WR     = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [N_RD*ADDR_W-1:0]   RdAddr,
  output logic [N_RD*DATA_W-1:0]   RdData,
  output logic [N_RD-1:0]          RdBusy,
  input  logic [N_WR-1:0]          WrEn,
  input  logic [N_WR*ADDR_W-1:0]   WrAddr,
  input  logic [N_WR*DATA_W-1:0]   WrData,
  input  logic                     IssueEn,
  input  logic [ADDR_W-1:0]        IssueAddr,
  output logic                     WrConflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic [ADDR_W-1:0] rd_addr  [N_RD];
  logic [DATA_W-1:0] rd_val   [N_RD];
  logic [ADDR_W-1:0] wr_addr  [N_WR];
  logic [DATA_W-1:0] wr_data  [N_WR];
  logic [N_WR-1:0]   wr_valid;
  logic              issue_valid;
  logic              conflict_nxt;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  always_comb begin
    for (int p = 0; p < N_RD; p++) begin
      rd_addr[p] = RdAddr[p*ADDR_W +: ADDR_W];
    end
  end

  // Writes to a hardwired zero register are dropped here, so they never reach
  // storage, the scoreboard, the conflict detector or the bypass path.
  always_comb begin
    for (int w = 0; w < N_WR; w++) begin
      wr_addr[w]  = WrAddr[w*ADDR_W +: ADDR_W];
      wr_data[w]  = WrData[w*DATA_W +: DATA_W];
      wr_valid[w] = WrEn[w] && !is_zero_reg(WrAddr[w*ADDR_W +: ADDR_W]);
    end
  end

  assign issue_valid = IssueEn && !is_zero_reg(IssueAddr);

  always_comb begin
    conflict_nxt = 1'b0;
    for (int i = 0; i < N_WR; i++) begin
      for (int j = i + 1; j < N_WR; j++) begin
        if (wr_valid[i] && wr_valid[j] && (wr_addr[i] == wr_addr[j])) begin
          conflict_nxt = 1'b1;
        end
      end
    end
  end

  // Later ports overwrite earlier ones in the loop, giving highest-index priority.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= '0;
      end
    end else begin
      for (int w = 0; w < N_WR; w++) begin
        if (wr_valid[w]) begin
          mem[wr_addr[w]] <= wr_data[w];
        end
      end
    end
  end

  // Issue is applied after the write clears so a same-cycle issue keeps the register busy.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      busy <= '0;
    end else begin
      for (int w = 0; w < N_WR; w++) begin
        if (wr_valid[w]) begin
          busy[wr_addr[w]] <= 1'b0;
        end
      end
      if (issue_valid) begin
        busy[IssueAddr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      WrConflict <= 1'b0;
    end else begin
      WrConflict <= conflict_nxt;
    end
  end

  always_comb begin
    for (int p = 0; p < N_RD; p++) begin
      rd_val[p] = mem[rd_addr[p]];
      if (BYPASS != 0) begin
        for (int w = 0; w < N_WR; w++) begin
          if (wr_valid[w] && (wr_addr[w] == rd_addr[p])) begin
            rd_val[p] = wr_data[w];
          end
        end
      end
      if (is_zero_reg(rd_addr[p])) begin
        rd_val[p] = '0;
      end
    end
  end

  always_comb begin
    RdData = '0;
    RdBusy = '0;
    for (int p = 0; p < N_RD; p++) begin
      RdData[p*DATA_W +: DATA_W] = rd_val[p];
      RdBusy[p]                  = busy[rd_addr[p]];
    end
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: default build (bypass, no zero reg) side by side
// with a ZERO_REG=1 / BYPASS=0 build driven by the same stimulus.
module tb_param_reg_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_RD   = 2;
  localparam int N_WR   = 2;
  localparam logic [31:0] NEG2 = 32'hFFFF_FFFE;
  localparam logic [31:0] NEG2000 = 32'hFFFF_F830;

  logic                   Clk;
  logic                   Rst;
  logic [N_RD*ADDR_W-1:0] RdAddr;
  logic [N_WR-1:0]        WrEn;
  logic [N_WR*ADDR_W-1:0] WrAddr;
  logic [N_WR*DATA_W-1:0] WrData;
  logic                   IssueEn;
  logic [ADDR_W-1:0]      IssueAddr;

  logic [N_RD*DATA_W-1:0] RdData, RdData_z;
  logic [N_RD-1:0]        RdBusy, RdBusy_z;
  logic                   WrConflict, WrConflict_z;

  int n_checks = 0;
  int n_fail   = 0;

  param_reg_file dut (
    .Clk(Clk), .Rst(Rst), .RdAddr(RdAddr), .RdData(RdData), .RdBusy(RdBusy),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .IssueEn(IssueEn),
    .IssueAddr(IssueAddr), .WrConflict(WrConflict)
  );

  param_reg_file #(.ZERO_REG(1), .BYPASS(0)) dut_z (
    .Clk(Clk), .Rst(Rst), .RdAddr(RdAddr), .RdData(RdData_z), .RdBusy(RdBusy_z),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .IssueEn(IssueEn),
    .IssueAddr(IssueAddr), .WrConflict(WrConflict_z)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic idle();
    WrEn    = '0;
    IssueEn = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
    RdAddr[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic set_wr(input int w, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    WrEn[w] = 1'b1;
    WrAddr[w*ADDR_W +: ADDR_W] = a;
    WrData[w*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset();
    logic [31:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    @(negedge Clk);
    set_wr(0, 5'd2, d0);
    set_wr(1, 5'd2, d1);
    IssueEn = 1'b1; IssueAddr = 5'd2;
    set_rd(0, 5'd2);
    set_rd(1, 5'd2);
    @(negedge Clk);
    idle();
    #1;
    n_checks++;
    if (RdData[31:0] !== d1) begin
      n_fail++; $display("FAIL rst_prefill_data got %h exp %h", RdData[31:0], d1);
    end
    n_checks++;
    if (RdBusy[0] !== 1'b1 || WrConflict !== 1'b1) begin
      n_fail++; $display("FAIL rst_prefill_state busy %b conf %b exp 1 1", RdBusy[0], WrConflict);
    end
    #1 Rst = 1'b1;
    #1;
    n_checks++;
    if (RdData !== '0 || RdData_z !== '0) begin
      n_fail++; $display("FAIL rst_data got %h / %h exp 0", RdData, RdData_z);
    end
    n_checks++;
    if (RdBusy !== '0 || RdBusy_z !== '0 || WrConflict !== 1'b0 || WrConflict_z !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags busy %b/%b conf %b/%b exp 0", RdBusy, RdBusy_z, WrConflict, WrConflict_z);
    end
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge Clk);
    set_wr(0, 5'd1, 32'd1200);
    set_rd(0, 5'd1);
    set_rd(1, 5'd31);
    #1;
    n_checks++;
    if (RdData_z[31:0] !== 32'd0) begin
      n_fail++; $display("FAIL wr_nobypass_old got %h exp 0", RdData_z[31:0]);
    end
    @(negedge Clk);
    idle();
    set_wr(1, 5'd31, NEG2);
    #1;
    n_checks++;
    if (RdData[31:0] !== 32'd1200 || RdData_z[31:0] !== 32'd1200) begin
      n_fail++; $display("FAIL wr_rd1200 got %h / %h exp %h", RdData[31:0], RdData_z[31:0], 32'd1200);
    end
    @(negedge Clk);
    idle();
    #1;
    n_checks++;
    if (RdData[63:32] !== NEG2 || RdData_z[63:32] !== NEG2) begin
      n_fail++; $display("FAIL wr_rd_neg2 got %h / %h exp %h", RdData[63:32], RdData_z[63:32], NEG2);
    end
    n_checks++;
    if (WrConflict !== 1'b0) begin
      n_fail++; $display("FAIL wr_no_conflict got %b exp 0", WrConflict);
    end
  endtask

  task automatic test_bypass();
    @(negedge Clk);
    set_wr(0, 5'd3, 32'd777);
    @(negedge Clk);
    idle();
    set_wr(0, 5'd3, NEG2000);
    set_rd(1, 5'd3);
    #1;
    n_checks++;
    if (RdData[63:32] !== NEG2000) begin
      n_fail++; $display("FAIL bypass_fwd got %h exp %h", RdData[63:32], NEG2000);
    end
    n_checks++;
    if (RdData_z[63:32] !== 32'd777) begin
      n_fail++; $display("FAIL bypass_off_old got %h exp %h", RdData_z[63:32], 32'd777);
    end
    @(negedge Clk);
    idle();
    #1;
    n_checks++;
    if (RdData[63:32] !== NEG2000 || RdData_z[63:32] !== NEG2000) begin
      n_fail++; $display("FAIL bypass_stored got %h / %h exp %h", RdData[63:32], RdData_z[63:32], NEG2000);
    end
  endtask

  task automatic test_conflict();
    @(negedge Clk);
    set_wr(0, 5'd5, 32'd10);
    set_wr(1, 5'd5, 32'd20);
    set_rd(0, 5'd5);
    #1;
    n_checks++;
    if (RdData[31:0] !== 32'd20) begin
      n_fail++; $display("FAIL conf_bypass_prio got %h exp %h", RdData[31:0], 32'd20);
    end
    @(negedge Clk);
    idle();
    set_wr(0, 5'd6, 32'd66);
    set_wr(1, 5'd8, 32'd88);
    set_rd(1, 5'd6);
    #1;
    n_checks++;
    if (RdData[31:0] !== 32'd20 || RdData_z[31:0] !== 32'd20) begin
      n_fail++; $display("FAIL conf_stored got %h / %h exp %h", RdData[31:0], RdData_z[31:0], 32'd20);
    end
    n_checks++;
    if (WrConflict !== 1'b1 || WrConflict_z !== 1'b1) begin
      n_fail++; $display("FAIL conf_pulse got %b / %b exp 1", WrConflict, WrConflict_z);
    end
    @(negedge Clk);
    idle();
    set_rd(0, 5'd8);
    #1;
    n_checks++;
    if (WrConflict !== 1'b0 || WrConflict_z !== 1'b0) begin
      n_fail++; $display("FAIL conf_clear got %b / %b exp 0", WrConflict, WrConflict_z);
    end
    n_checks++;
    if (RdData_z[31:0] !== 32'd88 || RdData_z[63:32] !== 32'd66) begin
      n_fail++; $display("FAIL conf_distinct got %h %h exp 88 66", RdData_z[31:0], RdData_z[63:32]);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge Clk);
    IssueEn = 1'b1; IssueAddr = 5'd7;
    set_rd(0, 5'd7);
    #1;
    n_checks++;
    if (RdBusy[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_not_yet got %b exp 0", RdBusy[0]);
    end
    @(negedge Clk);
    idle();
    #1;
    n_checks++;
    if (RdBusy[0] !== 1'b1 || RdBusy_z[0] !== 1'b1) begin
      n_fail++; $display("FAIL sb_issue got %b / %b exp 1", RdBusy[0], RdBusy_z[0]);
    end
    set_wr(0, 5'd7, 32'd1);
    @(negedge Clk);
    idle();
    #1;
    n_checks++;
    if (RdBusy[0] !== 1'b0 || RdBusy_z[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_write_clear got %b / %b exp 0", RdBusy[0], RdBusy_z[0]);
    end
    set_wr(1, 5'd7, 32'd2);
    IssueEn = 1'b1; IssueAddr = 5'd7;
    @(negedge Clk);
    idle();
    #1;
    n_checks++;
    if (RdBusy[0] !== 1'b1 || RdBusy_z[0] !== 1'b1) begin
      n_fail++; $display("FAIL sb_issue_wins got %b / %b exp 1", RdBusy[0], RdBusy_z[0]);
    end
    set_wr(1, 5'd7, 32'd3);
    @(negedge Clk);
    idle();
    #1;
    n_checks++;
    if (RdBusy[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_port1_clear got %b exp 0", RdBusy[0]);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge Clk);
    set_wr(0, 5'd0, 32'd55);
    set_wr(1, 5'd0, 32'd66);
    IssueEn = 1'b1; IssueAddr = 5'd0;
    set_rd(0, 5'd0);
    #1;
    n_checks++;
    if (RdData[31:0] !== 32'd66 || RdData_z[31:0] !== 32'd0) begin
      n_fail++; $display("FAIL zr_same_cycle got %h / %h exp 66 0", RdData[31:0], RdData_z[31:0]);
    end
    @(negedge Clk);
    idle();
    #1;
    n_checks++;
    if (RdData_z[31:0] !== 32'd0 || RdBusy_z[0] !== 1'b0 || WrConflict_z !== 1'b0) begin
      n_fail++; $display("FAIL zr_ignored data %h busy %b conf %b exp 0 0 0", RdData_z[31:0], RdBusy_z[0], WrConflict_z);
    end
    n_checks++;
    if (RdData[31:0] !== 32'd66 || RdBusy[0] !== 1'b1 || WrConflict !== 1'b1) begin
      n_fail++; $display("FAIL zr_plain_reg0 data %h busy %b conf %b exp 66 1 1", RdData[31:0], RdBusy[0], WrConflict);
    end
    @(negedge Clk);
    set_wr(0, 5'd9, 32'd99);
    set_rd(0, 5'd9);
    set_rd(1, 5'd1);
    #2 Rst = 1'b1;
    @(negedge Clk);
    idle();
    Rst = 1'b0;
    #1;
    n_checks++;
    if (RdData !== '0 || RdData_z !== '0) begin
      n_fail++; $display("FAIL zr_rst_midwrite got %h / %h exp 0", RdData, RdData_z);
    end
    @(negedge Clk);
    set_wr(0, 5'd9, 32'd123);
    @(negedge Clk);
    idle();
    #1;
    n_checks++;
    if (RdData[31:0] !== 32'd123) begin
      n_fail++; $display("FAIL post_rst_write got %h exp %h", RdData[31:0], 32'd123);
    end
  endtask

  initial begin
    Rst = 1'b1;
    RdAddr = '0; WrAddr = '0; WrData = '0; IssueAddr = '0;
    idle();
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_zero_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
